sync_mod_up_counter: RTL and testbench

Synchronous, fully clocked modulo-N up counter with enable, clear, parallel load, terminal-count carry, compare match and sticky overflow. It counts in the opposite direction to the team's ripple down counter. Every bit changes on the same `clk` edge, so there is no ripple skew. It is the counting element for timers and sequencers, and `tc` allows multiple instances to be cascaded.

---
 rtl/sync_mod_up_counter.sv | 75 +++++++
 tb/tb_sync_mod_up_counter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/sync_mod_up_counter.sv
// sync_mod_up_counter
//   Fully synchronous modulo up counter (sequence 0 to modulus-1) with clear,
//   saturating parallel load, count enable, terminal-count carry, compare
//   match and a sticky overflow flag.
module sync_mod_up_counter #(
  parameter int unsigned W   = 3,
  parameter int unsigned MOD = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic [W-1:0] cmp_val,
  input  logic         ovf_clr,
  output logic [W-1:0] count,
  output logic         tc,
  output logic         wrap,
  output logic         cmp_hit,
  output logic         ovf
);

  generate
    if (MOD < 2 || MOD > (1 << W)) begin : g_bad_mod
      $error("sync_mod_up_counter: MOD must satisfy 2 <= MOD <= 2**W");
    end
  endgenerate

  // Terminal value held at W+1 bits so MOD = 2**W needs no special case.
  localparam logic [W:0] LAST = (W+1)'(MOD - 1);

  logic [W:0] count_ext;
  logic [W:0] count_inc;
  logic       at_last;
  logic       load_over;
  logic       wrap_now;

  always_comb begin
    count_ext = {1'b0, count};
    count_inc = count_ext + {{W{1'b0}}, 1'b1};
    at_last   = (count_ext == LAST);
    load_over = ({1'b0, load_val} > LAST);
    // A wrap happens only when counting is the winning action.
    wrap_now  = !clr && !load && en && at_last;
  end

  assign tc      = en && at_last;
  assign cmp_hit = (count == cmp_val);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      wrap  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      wrap <= wrap_now;
      if (clr) begin
        count <= '0;
      end else if (load) begin
        count <= load_over ? LAST[W-1:0] : load_val;
      end else if (en) begin
        // Explicit return to zero instead of relying on truncation.
        count <= at_last ? '0 : count_inc[W-1:0];
      end

      if (wrap_now) begin
        ovf <= 1'b1;
      end else if (ovf_clr) begin
        ovf <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sync_mod_up_counter.sv
module tb_sync_mod_up_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Shared stimulus for the MOD=8 (A) and MOD=10 (B) instances
    logic       rst = 1'b0, clr = 1'b0, load = 1'b0, en = 1'b0, ovf_clr = 1'b0;
    logic [3:0] lv = '0, cv = '0;

    logic [2:0] a_count;
    logic       a_tc, a_wrap, a_hit, a_ovf;
    logic [3:0] b_count;
    logic       b_tc, b_wrap, b_hit, b_ovf;

    // Cascade pair
    logic       casc_en = 1'b0;
    logic [2:0] zero3 = '0;
    logic [2:0] c0_count, c1_count;
    logic       c0_tc, c1_tc, c0_wrap, c1_wrap, c0_hit, c1_hit, c0_ovf, c1_ovf;

    sync_mod_up_counter #(.W(3), .MOD(8)) dut_a (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(lv[2:0]),
        .en(en), .cmp_val(cv[2:0]), .ovf_clr(ovf_clr),
        .count(a_count), .tc(a_tc), .wrap(a_wrap), .cmp_hit(a_hit), .ovf(a_ovf));

    sync_mod_up_counter #(.W(4), .MOD(10)) dut_b (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(lv),
        .en(en), .cmp_val(cv), .ovf_clr(ovf_clr),
        .count(b_count), .tc(b_tc), .wrap(b_wrap), .cmp_hit(b_hit), .ovf(b_ovf));

    sync_mod_up_counter #(.W(3), .MOD(8)) dut_c0 (
        .clk(clk), .rst(rst), .clr(1'b0), .load(1'b0), .load_val(zero3),
        .en(casc_en), .cmp_val(zero3), .ovf_clr(1'b0),
        .count(c0_count), .tc(c0_tc), .wrap(c0_wrap), .cmp_hit(c0_hit), .ovf(c0_ovf));

    sync_mod_up_counter #(.W(3), .MOD(8)) dut_c1 (
        .clk(clk), .rst(rst), .clr(1'b0), .load(1'b0), .load_val(zero3),
        .en(c0_tc), .cmp_val(zero3), .ovf_clr(1'b0),
        .count(c1_count), .tc(c1_tc), .wrap(c1_wrap), .cmp_hit(c1_hit), .ovf(c1_ovf));

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain arithmetic on the counter's rules
    typedef struct {
        int cnt;   // -1 while unknown (before first reset)
        int wrap;
        int ovf;
    } st_t;

    typedef struct {
        bit chk;   // combinational outputs checkable
        int tc;
        int hit;
        int cnt;
        int wrap;
        int ovf;
    } item_t;

    function automatic st_t next_st(input int mod, input st_t s, input bit r, input bit c,
                                    input bit l, input bit e, input bit oc, input int lval);
        st_t n;
        n = s;
        n.wrap = 0;
        if (r) begin
            n.cnt = 0;
            n.ovf = 0;
            return n;
        end
        if (c)      n.cnt = 0;
        else if (l) n.cnt = (lval < mod) ? lval : mod - 1;
        else if (e) begin
            n.wrap = (s.cnt + 1 == mod) ? 1 : 0;
            n.cnt  = (s.cnt + 1) % mod;
        end
        if (n.wrap == 1) n.ovf = 1;
        else if (oc)     n.ovf = 0;
        return n;
    endfunction

    st_t   sa = '{cnt: -1, wrap: 0, ovf: 0};
    st_t   sb = '{cnt: -1, wrap: 0, ovf: 0};
    item_t qa[$];
    item_t qb[$];

    function automatic item_t make_item(input int mod, input st_t s, input st_t n,
                                        input bit e, input int cmpv);
        item_t it;
        it.chk  = (s.cnt >= 0);
        it.tc   = (e && s.cnt == mod - 1) ? 1 : 0;
        it.hit  = (s.cnt == cmpv) ? 1 : 0;
        it.cnt  = n.cnt;
        it.wrap = n.wrap;
        it.ovf  = n.ovf;
        return it;
    endfunction

    // Drive one cycle of stimulus at the falling edge and push expectations.
    task automatic cycle(input bit r, input bit c, input bit l, input bit e, input bit oc,
                         input int lvv, input int cvv, input bit ce = 1'b0);
        st_t na, nb;
        @(negedge clk);
        rst = r; clr = c; load = l; en = e; ovf_clr = oc;
        lv = 4'(lvv); cv = 4'(cvv); casc_en = ce;
        na = next_st(8, sa, r, c, l, e, oc, lvv % 8);
        nb = next_st(10, sb, r, c, l, e, oc, lvv % 16);
        qa.push_back(make_item(8, sa, na, e, cvv % 8));
        qb.push_back(make_item(10, sb, nb, e, cvv % 16));
        sa = na;
        sb = nb;
    endtask

    task automatic idle_cycles(input int n, input bit e, input int cvv);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, e, 1'b0, 0, cvv);
    endtask

    // Monitor: combinational outputs just after inputs settle, registered ones after the edge
    initial begin
        item_t it;
        forever begin
            @(negedge clk);
            #2;
            if (qa.size() > 0 && qa[0].chk) begin
                check("a_tc", int'(a_tc), qa[0].tc);
                check("a_cmp_hit", int'(a_hit), qa[0].hit);
            end
            if (qb.size() > 0 && qb[0].chk) begin
                check("b_tc", int'(b_tc), qb[0].tc);
                check("b_cmp_hit", int'(b_hit), qb[0].hit);
            end
            @(posedge clk);
            #1;
            if (qa.size() > 0) begin
                it = qa.pop_front();
                check("a_count", int'(a_count), it.cnt);
                check("a_wrap", int'(a_wrap), it.wrap);
                check("a_ovf", int'(a_ovf), it.ovf);
            end
            if (qb.size() > 0) begin
                it = qb.pop_front();
                check("b_count", int'(b_count), it.cnt);
                check("b_wrap", int'(b_wrap), it.wrap);
                check("b_ovf", int'(b_ovf), it.ovf);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with en/load active
        cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5, 0);
        cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5, 0);
        // Full count sequence with wrap
        idle_cycles(8, 1'b1, 0);
        // Clear ovf while idle
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0);
        // Count to 7 then wrap together with ovf_clr: set wins
        idle_cycles(7, 1'b1, 0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0);
        // Priority
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3, 0);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 6, 0);
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6, 0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
        // Compare at 4
        idle_cycles(12, 1'b1, 4);
        // Saturating load (B sees 12 -> 9), then wrap
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 12, 0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
        // Out-of-range compare for B
        idle_cycles(30, 1'b1, 12);
        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            cycle(($urandom_range(31) == 0), ($urandom_range(9) == 0),
                  ($urandom_range(7) == 0), ($urandom_range(3) != 0),
                  ($urandom_range(5) == 0), int'($urandom_range(15)),
                  int'($urandom_range(15)));
        end
        // Cascade: reset, then 64 enabled cycles
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        for (int i = 1; i <= 64; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
            @(posedge clk);
            #1;
            check("cascade_count", int'({c1_count, c0_count}), i % 64);
            check("cascade_wrap1", int'(c1_wrap), (i == 64) ? 1 : 0);
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
        repeat (2) @(posedge clk);
        #3;
        check("scoreboard_a_drained", qa.size(), 0);
        check("scoreboard_b_drained", qb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
